up_down_counter: RTL and testbench
==================================

// Module: up_down_counter
// PURPOSE
//   Synchronous modulo-N up/down counter with a single direction control.
//   Default is 8 states (0..7) on a 4-bit output bus.
//   The value steps once per clock, up or down as selected by mode, and wraps
//   at both ends.
//   Intended as a small sequencing/state-index source for control logic.
// PARAMETERS
//   WIDTH       4  output bus width in bits
//   NUM_STATES  8  count modulus; legal range 2..2**WIDTH; sequence is 0..NUM_STATES-1
// PORTS
//   clk       input   1      clock; all state updates on rising edge
//   rst       input   1      synchronous, active-low reset (sampled on rising clk edge)
//   mode      input   1      direction: 1 = count up, 0 = count down
//   data_out  output  WIDTH  current count, driven directly from a register
// BEHAVIOUR
//   - Clocking: one clock (clk). Reset is synchronous and active-low: rst==0 at a
//     rising clk edge forces the count to 0. No asynchronous reset path.
//   - Reset value: data_out = 0. Reset overrides mode.
//   - Counting, evaluated at each rising edge with rst==1:
//     - mode==1: count <= (count == NUM_STATES-1) ? 0 : count+1
//     - mode==0: count <= (count == 0) ? NUM_STATES-1 : count-1
//   - Latency: one cycle. data_out reflects the update right after the edge.
//     No combinational path from mode or rst to data_out.
//   - Mode change: takes effect at the first edge that samples the new value.
//     No dead cycle and no extra hold cycle when direction reverses.
//   - Wrap-around:
//     - 7 -> 0 when counting up (default NUM_STATES).
//     - 0 -> 7 when counting down.
//     - Wrap uses the NUM_STATES compare, never natural WIDTH rollover.
//   - Bits above the needed range (MSB with defaults) read 0 in every reachable state.
//   - Illegal state (count >= NUM_STATES, e.g. after an upset): the next edge
//     loads 0 regardless of mode.
//   - Reset mid-count: the count returns to 0 on that edge. Counting resumes from 0
//     on the first edge with rst==1, in the direction given by mode.
//   - Parameter check: elaboration-time error if NUM_STATES < 2 or NUM_STATES > 2**WIDTH.
// STRUCTURE
//   - Single always_ff/always @(posedge clk) register with next-state logic.
//   - Direction encoding goes in the shared package: localparam DIR_UP = 1'b1,
//     DIR_DOWN = 1'b0.
//   - No sub-module. Next-state function (up/down/wrap/illegal) in one combinational
//     block or function.
// TESTING
//   1. Hold rst=0 for 2 edges, then release -> data_out = 0 while in reset and on
//      the first release cycle boundary.
//   2. rst=1, mode=1 for 9 edges from 0 -> 1,2,3,4,5,6,7,0,1 (checks up-wrap 7->0).
//   3. From 1, mode=0 for 4 edges -> 0,7,6,5 (checks down-wrap 0->7).
//   4. Toggle mode each edge starting at 3 with mode=1,0,1,0 -> 4,3,4,3
//      (immediate reversal, no lost cycle).
//   5. Count up to 5, assert rst=0 for 1 edge with mode=1 -> 0. Release -> 1,2...
//      (reset dominates mode, restart from 0).
//   6. Params WIDTH=4, NUM_STATES=16, mode=1 from 15 -> 0. NUM_STATES=5, mode=0
//      from 0 -> 4.

Source files
------------

// File: rtl/up_down_counter_pkg.sv
// rtl/up_down_counter_pkg.sv - shared direction encoding for up_down_counter
package up_down_counter_pkg;

  // Level of the mode input that selects each counting direction
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - modulo-NUM_STATES up/down counter with direction select
module up_down_counter
  import up_down_counter_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int NUM_STATES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out
);

  // Reject moduli that cannot be represented or cannot count at elaboration time
  if (NUM_STATES < 2 || longint'(NUM_STATES) > (64'd1 << WIDTH)) begin : g_bad_params
    $error("up_down_counter: NUM_STATES must lie in 2..2**WIDTH");
  end

  // Highest legal count; wrap is decided against this value, never by bus rollover
  localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_STATES - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next-state: out-of-range recovery first, then step or wrap in the selected direction
  always_comb begin
    count_d = count_q;
    if (count_q > LAST) begin
      count_d = '0;
    end else if (mode == DIR_UP) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end else begin
      count_d = (count_q == '0) ? LAST : count_q - WIDTH'(1);
    end
  end

  // Count register; a low rst at the edge wins over any counting
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign data_out = count_q;

endmodule : up_down_counter

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - scoreboard bench for up_down_counter at three moduli
module tb_up_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mode = 1'b1;
  logic [3:0] out8, out16, out5;

  up_down_counter #(.WIDTH(4), .NUM_STATES(8))  dut8  (.clk(clk), .rst(rst), .mode(mode), .data_out(out8));
  up_down_counter #(.WIDTH(4), .NUM_STATES(16)) dut16 (.clk(clk), .rst(rst), .mode(mode), .data_out(out16));
  up_down_counter #(.WIDTH(4), .NUM_STATES(5))  dut5  (.clk(clk), .rst(rst), .mode(mode), .data_out(out5));

  always #5 clk = ~clk;

  typedef struct {
    int e8;
    int e16;
    int e5;
    int tag;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m8 = 0, m16 = 0, m5 = 0;
  int   step_no = 0;

  function automatic int ref_next(input int cur, input int n, input logic r, input logic m);
    if (!r)     return 0;
    if (m)      return (cur + 1) % n;
    return (cur + n - 1) % n;
  endfunction

  // Drive one cycle of stimulus; a literal >= 0 overrides the model for that instance
  task automatic drive(input logic r, input logic m, input int l8 = -1, input int l16 = -1, input int l5 = -1);
    exp_t e;
    @(negedge clk);
    rst  = r;
    mode = m;
    m8  = ref_next(m8, 8, r, m);
    m16 = ref_next(m16, 16, r, m);
    m5  = ref_next(m5, 5, r, m);
    e.e8  = (l8  >= 0) ? l8  : m8;
    e.e16 = (l16 >= 0) ? l16 : m16;
    e.e5  = (l5  >= 0) ? l5  : m5;
    e.tag = step_no;
    step_no++;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, tag, act, exp);
    end
  endtask

  // Monitor: every edge produces a new count, so pop one expectation per edge
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("count_mod8",  e.tag, int'(out8),  e.e8);
      chk("count_mod16", e.tag, int'(out16), e.e16);
      chk("count_mod5",  e.tag, int'(out5),  e.e5);
    end
  end

  initial begin
    int vals[9];
    int budget;

    // Reset held for two edges
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // Count up across the 7 -> 0 wrap
    vals = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    for (int i = 0; i < 9; i++) drive(1, 1, vals[i]);
    // Count down across the 0 -> 7 wrap
    drive(1, 0, 0); drive(1, 0, 7); drive(1, 0, 6); drive(1, 0, 5);
    // Down to 3, then reverse every edge
    drive(1, 0, 4); drive(1, 0, 3);
    drive(1, 1, 4); drive(1, 0, 3); drive(1, 1, 4); drive(1, 0, 3);
    // Up to 5, reset with mode up, resume from 0
    drive(1, 1, 4); drive(1, 1, 5);
    drive(0, 1, 0, 0, 0);
    drive(1, 1, 1); drive(1, 1, 2);
    // Down-wrap at every modulus from 0, then up-wrap at every modulus from the top
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 7, 15, 4);
    drive(1, 1, 0, 0, 0);
    // Randomized traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) != 0), $urandom_range(0, 1));
    end
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_up_down_counter
